// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - 4-channel DMA hold-request/grant arbiter with fixed or rotating priority
// Optional rotation enabled by DMA_ROTATE_PRIORITY_EN.
module dma_channel_arbiter #(
    parameter int REQ_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] maskReg,
    input  logic       priorityType,
    input  logic       HLDA,
    input  logic       transferDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] grantChannel,
    output logic [7:0] priorityOrder,
    output logic       timeoutErr
);

    localparam int CNT_W = $clog2(REQ_TIMEOUT + 1);
    localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        HOLDREQ = 4'b0010,
        GRANT   = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    state_t state, next_state;
    logic [3:0]       pending;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       grant_ch;
    logic [1:0]       winner;
    logic [7:0]       order_q;
    logic             timed_out;

    assign pending       = DREQ & ~maskReg;
    assign grantChannel  = grant_ch;
    assign priorityOrder = order_q;

    // First pending channel when walking the order from highest to lowest field
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (!found && pending[order_q[2*i +: 2]]) begin
                winner = order_q[2*i +: 2];
                found  = 1'b1;
            end
        end
    end

    assign timed_out = (state == HOLDREQ) && (pending != 4'b0000) && !HLDA &&
                       (wait_cnt == CNT_W'(REQ_TIMEOUT - 1));

    // Outputs decode straight from state so an async reset clears them without a clock
    always_comb begin
        next_state = state;
        HRQ        = 1'b0;
        DACK       = 4'b0000;
        timeoutErr = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 4'b0000)
                    next_state = HOLDREQ;
            end
            HOLDREQ: begin
                HRQ        = 1'b1;
                timeoutErr = timed_out;
                if (pending == 4'b0000)
                    next_state = IDLE;
                else if (HLDA)
                    next_state = GRANT;
                else if (timed_out)
                    next_state = IDLE;
            end
            GRANT: begin
                HRQ  = 1'b1;
                DACK = 4'b0001 << grant_ch;
                if (transferDone || !HLDA)
                    next_state = RELEASE;
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
            grant_ch <= 2'b00;
        end else begin
            state <= next_state;
            if (state == HOLDREQ && next_state == HOLDREQ)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == HOLDREQ && next_state == GRANT)
                grant_ch <= winner;
        end
    end

`ifdef DMA_ROTATE_PRIORITY_EN
    logic [7:0] rotated;

    // Served channel drops to the lowest field; the next one up becomes highest
    always_comb begin
        rotated = DEFAULT_ORDER;
        for (int i = 0; i < 4; i++)
            rotated[2*i +: 2] = grant_ch + 2'(i + 1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            order_q <= DEFAULT_ORDER;
        else if (!priorityType)
            order_q <= DEFAULT_ORDER;
        else if (state == RELEASE)
            order_q <= rotated;
    end
`else
    logic unused_priority_type;
    assign unused_priority_type = priorityType;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            order_q <= DEFAULT_ORDER;
        else
            order_q <= DEFAULT_ORDER;
    end
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - directed self-checking bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] DREQ = 4'b0000;
    logic [3:0] maskReg = 4'b0000;
    logic       priorityType = 1'b0;
    logic       HLDA = 1'b0;
    logic       transferDone = 1'b0;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] grantChannel;
    logic [7:0] priorityOrder;
    logic       timeoutErr;

    int tests = 0;
    int fails = 0;

    dma_channel_arbiter #(.REQ_TIMEOUT(16)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .DREQ(DREQ),
        .maskReg(maskReg),
        .priorityType(priorityType),
        .HLDA(HLDA),
        .transferDone(transferDone),
        .HRQ(HRQ),
        .DACK(DACK),
        .grantChannel(grantChannel),
        .priorityOrder(priorityOrder),
        .timeoutErr(timeoutErr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (HRQ !== 1'b0) begin fails++; $display("FAIL reset_hrq got %b exp 0", HRQ); end
        tests++; if (DACK !== 4'b0000) begin fails++; $display("FAIL reset_dack got %b exp 0000", DACK); end
        tests++; if (grantChannel !== 2'b00) begin fails++; $display("FAIL reset_grant got %b exp 00", grantChannel); end
        tests++; if (timeoutErr !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", timeoutErr); end
        tests++; if (priorityOrder !== 8'hE4) begin fails++; $display("FAIL reset_order got %h exp e4", priorityOrder); end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        DREQ = 4'b1110; maskReg = 4'b0000; priorityType = 1'b0; HLDA = 1'b1;
        tick();
        tests++; if (HRQ !== 1'b1 || DACK !== 4'b0000) begin fails++; $display("FAIL fixed_hrq_cycle1 got hrq=%b dack=%b exp 1/0000", HRQ, DACK); end
        tick();
        tests++; if (DACK !== 4'b0010) begin fails++; $display("FAIL fixed_dack_cycle2 got %b exp 0010", DACK); end
        tests++; if (grantChannel !== 2'd1) begin fails++; $display("FAIL fixed_grant got %0d exp 1", grantChannel); end
        DREQ = 4'b0001; maskReg = 4'b0010;
        tick();
        tests++; if (DACK !== 4'b0010) begin fails++; $display("FAIL fixed_no_preempt got %b exp 0010", DACK); end
        transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        tests++; if (HRQ !== 1'b0 || DACK !== 4'b0000) begin fails++; $display("FAIL fixed_release got hrq=%b dack=%b exp 0/0000", HRQ, DACK); end
        DREQ = 4'b0000; maskReg = 4'b0000;
        tick();
        tests++; if (priorityOrder !== 8'hE4) begin fails++; $display("FAIL fixed_order got %h exp e4", priorityOrder); end
    endtask

    task automatic test_mask_withdraw();
        DREQ = 4'b0001; maskReg = 4'b0001; HLDA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (HRQ !== 1'b0) begin fails++; $display("FAIL masked_hrq cycle %0d got %b exp 0", i, HRQ); end
        end
        maskReg = 4'b0000;
        tick();
        tests++; if (HRQ !== 1'b1) begin fails++; $display("FAIL unmasked_hrq got %b exp 1", HRQ); end
        DREQ = 4'b0000;
        tick();
        tests++; if (HRQ !== 1'b0 || DACK !== 4'b0000 || timeoutErr !== 1'b0) begin fails++; $display("FAIL withdraw got hrq=%b dack=%b err=%b exp 0/0000/0", HRQ, DACK, timeoutErr); end
        tick();
        tests++; if (HRQ !== 1'b0) begin fails++; $display("FAIL withdraw_idle got %b exp 0", HRQ); end
    endtask

    task automatic test_timeout();
        int   pulses = 0;
        int   first = 0;
        logic dack_seen = 1'b0;
        logic hrq_next = 1'b1;
        DREQ = 4'b0001; HLDA = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (DACK !== 4'b0000) dack_seen = 1'b1;
            if (first != 0 && i == first + 1) hrq_next = HRQ;
            if (timeoutErr === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
                DREQ = 4'b0000;
            end
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
        tests++; if (first != 16) begin fails++; $display("FAIL timeout_cycle got %0d exp 16", first); end
        tests++; if (hrq_next !== 1'b0) begin fails++; $display("FAIL timeout_hrq_after got %b exp 0", hrq_next); end
        tests++; if (dack_seen !== 1'b0) begin fails++; $display("FAIL timeout_dack got %b exp 0", dack_seen); end
    endtask

    task automatic test_simultaneous();
        DREQ = 4'b0100; HLDA = 1'b1; priorityType = 1'b0;
        tick(); tick();
        tests++; if (DACK !== 4'b0100) begin fails++; $display("FAIL simul_grant got %b exp 0100", DACK); end
        transferDone = 1'b1; HLDA = 1'b0;
        tick();
        transferDone = 1'b0; HLDA = 1'b1;
        tests++; if (HRQ !== 1'b0 || DACK !== 4'b0000) begin fails++; $display("FAIL simul_release got hrq=%b dack=%b exp 0/0000", HRQ, DACK); end
        tick();
        tests++; if (HRQ !== 1'b0) begin fails++; $display("FAIL simul_idle got %b exp 0", HRQ); end
        tick();
        tests++; if (HRQ !== 1'b1) begin fails++; $display("FAIL simul_rerequest got %b exp 1", HRQ); end
        tick();
        tests++; if (DACK !== 4'b0100) begin fails++; $display("FAIL simul_regrant got %b exp 0100", DACK); end
        DREQ = 4'b0000; transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        tick();
    endtask

    task automatic test_rotation();
`ifdef DMA_ROTATE_PRIORITY_EN
        logic [3:0] dexp [3];
        logic [7:0] oexp [3];
        dexp[0] = 4'b0001; dexp[1] = 4'b0010; dexp[2] = 4'b0100;
        oexp[0] = 8'b00_11_10_01; oexp[1] = 8'b01_00_11_10; oexp[2] = 8'b10_01_00_11;
        priorityType = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); tick();
            tests++; if (DACK !== dexp[k]) begin fails++; $display("FAIL rot_dack %0d got %b exp %b", k, DACK, dexp[k]); end
            transferDone = 1'b1;
            tick();
            transferDone = 1'b0;
            tick();
            tests++; if (priorityOrder !== oexp[k]) begin fails++; $display("FAIL rot_order %0d got %b exp %b", k, priorityOrder, oexp[k]); end
        end
        DREQ = 4'b0000;
        tick();
`else
        priorityType = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(); tick();
            tests++; if (DACK !== 4'b0001) begin fails++; $display("FAIL norot_dack %0d got %b exp 0001", k, DACK); end
            transferDone = 1'b1;
            tick();
            transferDone = 1'b0;
            tick();
            tests++; if (priorityOrder !== 8'hE4) begin fails++; $display("FAIL norot_order %0d got %h exp e4", k, priorityOrder); end
        end
        DREQ = 4'b0000;
        tick();
`endif
    endtask

    task automatic test_reset_mid_grant();
        priorityType = 1'b1; DREQ = 4'b0100; HLDA = 1'b1;
        tick(); tick();
        tests++; if (DACK !== 4'b0100) begin fails++; $display("FAIL rstgrant_dack got %b exp 0100", DACK); end
        #2;
        RESET = 1'b1;
        #1;
        tests++; if (DACK !== 4'b0000 || HRQ !== 1'b0) begin fails++; $display("FAIL rstgrant_async got hrq=%b dack=%b exp 0/0000", HRQ, DACK); end
        tests++; if (priorityOrder !== 8'hE4) begin fails++; $display("FAIL rstgrant_order got %h exp e4", priorityOrder); end
        tick();
        RESET = 1'b0;
        DREQ = 4'b1111;
        tick(); tick();
        tests++; if (DACK !== 4'b0001) begin fails++; $display("FAIL rstgrant_first_grant got %b exp 0001", DACK); end
        DREQ = 4'b0000; transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_mask_withdraw();
        test_timeout();
        test_simultaneous();
        test_rotation();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
